writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/writeback_queue.sv | 129 ++++++++++++
 tb/tb_writeback_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and entry layout for the register-file writeback queue.
// Holds the default data/address widths, the default queue depth and the
// wb_entry_t {addr, data} record used for one pending register write.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 64;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DEPTH      = 4;

  // One pending register write at the default widths.
  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Purpose: circular {addr, data} store with two ordered push ports and one pop port.
// Latency: a pushed entry is visible at head / on the entry taps the cycle after the push edge.
// Backpressure: none internally; the caller must not push beyond DEPTH or pop when empty.
//
// Ports: clock, reset_n (async active-low); push_a_* is written before
// push_b_* on the same edge (push_a is the older entry); pop retires the head.
// head_addr/head_data show the oldest entry, count the occupancy, rd_ptr and
// the flat entry_addr/entry_data buses expose raw storage for bypass matching.
// DEPTH must be a power of two (pointers wrap by natural overflow) and >= 2.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = WB_DEPTH,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          push_a,
  input  logic [ADDR_WIDTH-1:0]         push_a_addr,
  input  logic [DATA_WIDTH-1:0]         push_a_data,
  input  logic                          push_b,
  input  logic [ADDR_WIDTH-1:0]         push_b_addr,
  input  logic [DATA_WIDTH-1:0]         push_b_data,
  input  logic                          pop,
  output logic [ADDR_WIDTH-1:0]         head_addr,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic [CW-1:0]                 count,
  output logic [PW-1:0]                 rd_ptr,
  output logic [DEPTH*ADDR_WIDTH-1:0]   entry_addr,
  output logic [DEPTH*DATA_WIDTH-1:0]   entry_data
);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]         wr_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Storage is not reset: occupancy (count/rd_ptr) decides what is live.
  // A lone push_b lands at wr_ptr; behind push_a it takes the next slot.
  always_ff @(posedge clock) begin
    if (push_a) begin
      mem_addr[wr_ptr] <= push_a_addr;
      mem_data[wr_ptr] <= push_a_data;
    end
    if (push_b) begin
      mem_addr[wr_ptr + PW'(push_a)] <= push_b_addr;
      mem_data[wr_ptr + PW'(push_a)] <= push_b_data;
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_taps
    assign entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = mem_addr[i];
    assign entry_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_data[i];
  end

endmodule

// File: rtl/writeback_queue.sv
// Purpose: merges ALU and load results into an in-order register-bank write stream.
// Latency: an accepted result drives write 1 cycle after its accepting edge; the bank pops every cycle.
// Backpressure: valid/ready per source; ALU has priority for the last free slot, readies low when full.
//
// Ports: clock, reset_n (async active-low); alu_* and load_* valid/ready
// producers; write/write_address/write_data to the register bank;
// lookup_address_n -> lookup_hit_n/lookup_data_n bypass probes;
// pending_count is the queue occupancy.
// Build option: define WB_BYPASS_EN to enable the bypass probes; otherwise
// the probe outputs are tied to 0.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_WIDTH-1:0]   alu_addr,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   write_address,
  output logic [DATA_WIDTH-1:0]   write_data,
  input  logic [ADDR_WIDTH-1:0]   lookup_address_1,
  input  logic [ADDR_WIDTH-1:0]   lookup_address_2,
  output logic                    lookup_hit_1,
  output logic                    lookup_hit_2,
  output logic [DATA_WIDTH-1:0]   lookup_data_1,
  output logic [DATA_WIDTH-1:0]   lookup_data_2,
  output logic [$clog2(DEPTH):0]  pending_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                        ready_en;
  logic                        alu_take;
  logic                        load_take;
  logic [ADDR_WIDTH-1:0]       head_addr;
  logic [DATA_WIDTH-1:0]       head_data;
  logic [PW-1:0]               rd_ptr;
  logic [DEPTH*ADDR_WIDTH-1:0] entry_addr;
  logic [DEPTH*DATA_WIDTH-1:0] entry_data;

  // Holds both readies low while in reset and releases them on the first
  // clock edge after reset_n deasserts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Readies look only at the registered count: a same-cycle pop frees nothing.
  // The load sees one slot fewer whenever the ALU is taking one this edge.
  assign alu_ready  = ready_en && (pending_count < CW'(DEPTH));
  assign alu_take   = alu_valid && alu_ready;
  assign load_ready = ready_en && (alu_take ? (pending_count < CW'(DEPTH - 1))
                                            : (pending_count < CW'(DEPTH)));
  assign load_take  = load_valid && load_ready;

  assign write         = (pending_count != '0);
  assign write_address = write ? head_addr : '0;
  assign write_data    = write ? head_data : '0;

  wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_a      (alu_take),
    .push_a_addr (alu_addr),
    .push_a_data (alu_data),
    .push_b      (load_take),
    .push_b_addr (load_addr),
    .push_b_data (load_data),
    .pop         (write),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (pending_count),
    .rd_ptr      (rd_ptr),
    .entry_addr  (entry_addr),
    .entry_data  (entry_data)
  );

`ifdef WB_BYPASS_EN
  logic [PW-1:0] slot;

  // Walk live entries oldest to youngest so the last match (youngest) wins.
  // Only stored entries are searched; this cycle's incoming payloads are not.
  always_comb begin
    lookup_hit_1  = 1'b0;
    lookup_hit_2  = 1'b0;
    lookup_data_1 = '0;
    lookup_data_2 = '0;
    slot          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if (CW'(k) < pending_count) begin
        if (entry_addr[slot*ADDR_WIDTH +: ADDR_WIDTH] == lookup_address_1) begin
          lookup_hit_1  = 1'b1;
          lookup_data_1 = entry_data[slot*DATA_WIDTH +: DATA_WIDTH];
        end
        if (entry_addr[slot*ADDR_WIDTH +: ADDR_WIDTH] == lookup_address_2) begin
          lookup_hit_2  = 1'b1;
          lookup_data_2 = entry_data[slot*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end
`else
  assign lookup_hit_1  = 1'b0;
  assign lookup_hit_2  = 1'b0;
  assign lookup_data_1 = '0;
  assign lookup_data_2 = '0;

  logic unused_bypass;
  assign unused_bypass = ^{lookup_address_1, lookup_address_2, rd_ptr,
                           entry_addr, entry_data};
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue at default parameters (64-bit data,
// 5-bit address, depth 4): a vector table for steady-state traffic plus
// hand-written sequences for reset and bypass behaviour.
module tb_writeback_queue;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid, load_valid;
  logic        alu_ready, load_ready;
  logic [4:0]  alu_addr, load_addr;
  logic [63:0] alu_data, load_data;
  logic        write;
  logic [4:0]  write_address;
  logic [63:0] write_data;
  logic [4:0]  lookup_address_1, lookup_address_2;
  logic        lookup_hit_1, lookup_hit_2;
  logic [63:0] lookup_data_1, lookup_data_2;
  logic [2:0]  pending_count;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_queue dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_addr         (alu_addr),
    .alu_data         (alu_data),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .write            (write),
    .write_address    (write_address),
    .write_data       (write_data),
    .lookup_address_1 (lookup_address_1),
    .lookup_address_2 (lookup_address_2),
    .lookup_hit_1     (lookup_hit_1),
    .lookup_hit_2     (lookup_hit_2),
    .lookup_data_1    (lookup_data_1),
    .lookup_data_2    (lookup_data_2),
    .pending_count    (pending_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        av;
    wb_entry_t   alu;
    logic        lv;
    wb_entry_t   ld;
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_w;
    logic [4:0]  exp_wa;
    logic [63:0] exp_wd;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [63:0] ad,
                              logic lv, logic [4:0] la, logic [63:0] ld,
                              logic ar, logic lr, logic w, logic [4:0] wa,
                              logic [63:0] wd, logic [2:0] cnt);
    vec_t v;
    v.av = av; v.alu.addr = aa; v.alu.data = ad;
    v.lv = lv; v.ld.addr = la;  v.ld.data = ld;
    v.exp_ar = ar; v.exp_lr = lr; v.exp_w = w;
    v.exp_wa = wa; v.exp_wd = wd; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                       input logic lv, input logic [4:0] la, input logic [63:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    load_valid = lv; load_addr = la; load_data = ld;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    lookup_address_1 = 5'd0;
    lookup_address_2 = 5'd0;

    //              av aa     ad      lv la     ld      ar lr w  wa     wd        cnt
    // Single ALU write.
    vecs[0]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 5'd0, 64'h0,    3'd0);
    vecs[1]  = mk(1, 5'd5,  64'h1234, 0, 5'd0, 64'h0,  1, 1, 0, 5'd0, 64'h0,    3'd0);
    vecs[2]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd5, 64'h1234, 3'd1);
    vecs[3]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 5'd0, 64'h0,    3'd0);
    // Simultaneous accept into an empty queue: ALU entry is the older one.
    vecs[4]  = mk(1, 5'd3,  64'hA,    1, 5'd3, 64'hB,  1, 1, 0, 5'd0, 64'h0,    3'd0);
    vecs[5]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd3, 64'hA,    3'd2);
    vecs[6]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd3, 64'hB,    3'd1);
    vecs[7]  = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 5'd0, 64'h0,    3'd0);
    // Both sources streaming: the bank pops every cycle, so the queue peaks
    // at 3; at 3 the ALU takes the last slot and the load is held off.
    vecs[8]  = mk(1, 5'd1,  64'h11,   1, 5'd2, 64'h22, 1, 1, 0, 5'd0, 64'h0,    3'd0);
    vecs[9]  = mk(1, 5'd3,  64'h33,   1, 5'd4, 64'h44, 1, 1, 1, 5'd1, 64'h11,   3'd2);
    vecs[10] = mk(1, 5'd5,  64'h55,   1, 5'd6, 64'h66, 1, 0, 1, 5'd2, 64'h22,   3'd3);
    // Held load goes in once the ALU is idle; then everything drains in order.
    vecs[11] = mk(0, 5'd0,  64'h0,    1, 5'd6, 64'h66, 1, 1, 1, 5'd3, 64'h33,   3'd3);
    vecs[12] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd4, 64'h44,   3'd3);
    vecs[13] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd5, 64'h55,   3'd2);
    vecs[14] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 1, 5'd6, 64'h66,   3'd1);
    vecs[15] = mk(0, 5'd0,  64'h0,    0, 5'd0, 64'h0,  1, 1, 0, 5'd0, 64'h0,    3'd0);

    // Reset state.
    #3;
    check("reset write", 64'(write), 64'd0);
    check("reset count", 64'(pending_count), 64'd0);
    check("reset alu_ready", 64'(alu_ready), 64'd0);
    check("reset load_ready", 64'(load_ready), 64'd0);
    check("reset write_data", write_data, 64'd0);
    check("reset hit_1", 64'(lookup_hit_1), 64'd0);
    #14;
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].alu.addr, vecs[i].alu.data,
            vecs[i].lv, vecs[i].ld.addr, vecs[i].ld.data);
      #1;
      check($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].exp_ar));
      check($sformatf("v%0d load_ready", i), 64'(load_ready), 64'(vecs[i].exp_lr));
      check($sformatf("v%0d write", i), 64'(write), 64'(vecs[i].exp_w));
      check($sformatf("v%0d write_address", i), 64'(write_address), 64'(vecs[i].exp_wa));
      check($sformatf("v%0d write_data", i), write_data, vecs[i].exp_wd);
      check($sformatf("v%0d pending_count", i), 64'(pending_count), 64'(vecs[i].exp_cnt));
      step();
    end

    // Reset mid-stream with three entries queued.
    drive(1, 5'd10, 64'hA0, 1, 5'd11, 64'hB0);
    step();
    drive(1, 5'd12, 64'hC0, 1, 5'd13, 64'hD0);
    step();
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    #1;
    check("pre-reset count", 64'(pending_count), 64'd3);
    check("pre-reset head", 64'(write_address), 64'd11);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-reset write", 64'(write), 64'd0);
    check("mid-reset count", 64'(pending_count), 64'd0);
    check("mid-reset write_address", 64'(write_address), 64'd0);
    check("mid-reset write_data", write_data, 64'd0);
    check("mid-reset alu_ready", 64'(alu_ready), 64'd0);
    check("mid-reset load_ready", 64'(load_ready), 64'd0);
    step();
    check("in-reset write", 64'(write), 64'd0);
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post-reset write c%0d", c), 64'(write), 64'd0);
      check($sformatf("post-reset count c%0d", c), 64'(pending_count), 64'd0);
      check($sformatf("post-reset alu_ready c%0d", c), 64'(alu_ready), 64'd1);
      check($sformatf("post-reset load_ready c%0d", c), 64'(load_ready), 64'd1);
    end

    // Two writes to register 7 queued together; probe 7 and 8.
    drive(1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
    lookup_address_1 = 5'd7;
    lookup_address_2 = 5'd8;
    #1;
    check("bypass incoming hit_1", 64'(lookup_hit_1), 64'd0);
    step();
    drive(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    #1;
`ifdef WB_BYPASS_EN
    check("bypass hit_1 two queued", 64'(lookup_hit_1), 64'd1);
    check("bypass data_1 youngest", lookup_data_1, 64'h2);
    check("bypass hit_2 miss", 64'(lookup_hit_2), 64'd0);
    check("bypass data_2 miss", lookup_data_2, 64'd0);
    step();
    check("bypass hit_1 one queued", 64'(lookup_hit_1), 64'd1);
    check("bypass data_1 one queued", lookup_data_1, 64'h2);
    step();
    check("bypass hit_1 drained", 64'(lookup_hit_1), 64'd0);
`else
    check("tied hit_1", 64'(lookup_hit_1), 64'd0);
    check("tied data_1", lookup_data_1, 64'd0);
    check("tied hit_2", 64'(lookup_hit_2), 64'd0);
    check("tied data_2", lookup_data_2, 64'd0);
    step();
    step();
`endif
    check("final count", 64'(pending_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
